// File: rtl/apb_arb_pkg.sv
// Shared types and sizes for the two-requester APB arbiter/master.
package apb_arb_pkg;

  localparam int NUM_REQ = 2;
  localparam int STRB_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

endpackage

// File: rtl/apb_rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, last-grant flop
// updated only when the grant is actually taken (advance).
module apb_rr_arb2
  import apb_arb_pkg::*;
(
  input  logic               pclk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] gnt
);

  logic last_q;
  logic last_d;

  // Grant decode: a lone requester wins, on contention the one not served last.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Remember who was served once the grant is consumed.
  always_comb begin
    last_d = last_q;
    if (advance) begin
      last_d = gnt[1];
    end else begin
      last_d = last_q;
    end
  end

  // Last-grant register; resetting to 1 gives requester 0 first priority.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/apb_arb_master.sv
// Two-requester APB master: round-robin grant, IDLE/SETUP/ACCESS sequencing,
// registered outputs. Optional ACCESS timeout with macro APB_ARB_TIMEOUT_EN.
module apb_arb_master
  import apb_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int TO_CYC = 16
) (
  input  logic                        pclk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  input  logic [NUM_REQ*STRB_W-1:0]   req_strb,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        rsp_err,
  output logic [ADDR_W-1:0]           paddr,
  output logic                        pwrite,
  output logic                        psel,
  output logic                        penable,
  output logic [DATA_W-1:0]           pwdata,
  output logic [STRB_W-1:0]           pstrb,
  input  logic [DATA_W-1:0]           prdata,
  input  logic                        pready
);

  if (TO_CYC < 1) begin : g_to_cyc_bad
    $error("apb_arb_master: TO_CYC must be at least 1");
  end

  state_e              state_q, state_d;
  logic                psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d, rsp_rdata_q, rsp_rdata_d;
  logic [STRB_W-1:0]   pstrb_q, pstrb_d;
  logic [NUM_REQ-1:0]  req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
  logic                grant_q, grant_d;
  logic [NUM_REQ-1:0]  arb_gnt;
  logic                any_gnt, gnt_idx, arb_advance;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TO_CYC + 1);
  logic [CNT_W-1:0]    to_cnt_q, to_cnt_d;
  logic                rsp_err_q, rsp_err_d;
`endif

  assign any_gnt     = |arb_gnt;
  assign gnt_idx     = arb_gnt[1];
  assign arb_advance = (state_q == IDLE) && any_gnt;

  apb_rr_arb2 u_arb (
    .pclk    (pclk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (arb_advance),
    .gnt     (arb_gnt)
  );

  // Next-state and registered-output computation for the transfer sequencer.
  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    grant_d     = grant_q;
    req_ready_d = 2'b00;
    rsp_valid_d = 2'b00;
    rsp_rdata_d = rsp_rdata_q;
`ifdef APB_ARB_TIMEOUT_EN
    rsp_err_d   = 1'b0;
    to_cnt_d    = to_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_gnt) begin
          grant_d              = gnt_idx;
          req_ready_d[gnt_idx] = 1'b1;
          pwrite_d             = req_write[gnt_idx];
          paddr_d              = gnt_idx ? req_addr[2*ADDR_W-1:ADDR_W]   : req_addr[ADDR_W-1:0];
          pwdata_d             = gnt_idx ? req_wdata[2*DATA_W-1:DATA_W]  : req_wdata[DATA_W-1:0];
          pstrb_d              = gnt_idx ? req_strb[2*STRB_W-1:STRB_W]   : req_strb[STRB_W-1:0];
          psel_d               = 1'b1;
          state_d              = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
        to_cnt_d  = '0;
`endif
      end
      ACCESS: begin
        if (pready) begin
          psel_d               = 1'b0;
          penable_d            = 1'b0;
          rsp_valid_d[grant_q] = 1'b1;
          rsp_rdata_d          = pwrite_q ? '0 : prdata;
          state_d              = IDLE;
        end else begin
`ifdef APB_ARB_TIMEOUT_EN
          // to_cnt_q counts completed stalled ACCESS cycles before this one.
          if (to_cnt_q == CNT_W'(TO_CYC - 1)) begin
            psel_d               = 1'b0;
            penable_d            = 1'b0;
            rsp_valid_d[grant_q] = 1'b1;
            rsp_err_d            = 1'b1;
            rsp_rdata_d          = '0;
            state_d              = IDLE;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
`else
          state_d = ACCESS;
`endif
        end
      end
      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      grant_q     <= 1'b0;
      req_ready_q <= 2'b00;
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      grant_q     <= grant_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

`ifdef APB_ARB_TIMEOUT_EN
  // Timeout counter and error flag.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q  <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign pstrb     = pstrb_q;
  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule
